rtdf_sample_unpacker: RTL and testbench

// Parametrised successor to the real-time data feed sample generator. Unpacks a

---
 rtl/rtdf_sample_unpacker.sv | 108 ++++++++++
 tb/tb_rtdf_sample_unpacker.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtdf_sample_unpacker.sv
// Real-time data feed sample unpacker: turns a stream of WORD_W-bit FIFO words
// into SAMPLE_W-bit samples, carrying leftover bits across word boundaries.
module rtdf_sample_unpacker #(
  parameter int WORD_W    = 16,
  parameter int SAMPLE_W  = 3,
  parameter int LSB_FIRST = 1,
  parameter int CNT_W     = 32,
  parameter int UF_W      = 16,
  localparam int BUF_W    = WORD_W + SAMPLE_W - 1,
  localparam int NB_W     = $clog2(BUF_W + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                word_empty,
  input  logic [WORD_W-1:0]   word_data,
  output logic                word_read,
  input  logic                sample_en,
  input  logic                flush,
  input  logic                halt,
  output logic                sample_valid,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic [NB_W-1:0]     bits_available,
  output logic [CNT_W-1:0]    sample_count,
  output logic [UF_W-1:0]     underflow_count
);

  logic [BUF_W-1:0]    bits_q, bits_d;
  logic [NB_W-1:0]     nb_q, nb_d;
  logic                valid_q, valid_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [UF_W-1:0]     uf_q, uf_d;

  logic              active;
  logic              take;
  logic [NB_W-1:0]   rem;
  logic [WORD_W-1:0] w;
  logic [BUF_W-1:0]  w_ext;
  logic [BUF_W-1:0]  kept;

  // MSB-first feeds are reversed once on load so unpacking is always LSB-first
  if (LSB_FIRST != 0) begin : g_lsb
    assign w = word_data;
  end else begin : g_msb
    for (genvar i = 0; i < WORD_W; i++) begin : g_rev
      assign w[i] = word_data[WORD_W-1-i];
    end
  end

  assign w_ext = BUF_W'(w);

  always_comb begin
    active    = !reset && !flush && !halt;
    take      = active && sample_en && (nb_q >= NB_W'(SAMPLE_W));
    rem       = take ? nb_q - NB_W'(SAMPLE_W) : nb_q;
    word_read = active && !word_empty && (rem < NB_W'(SAMPLE_W));
    kept      = take ? bits_q >> SAMPLE_W : bits_q;
  end

  always_comb begin
    bits_d  = bits_q;
    nb_d    = nb_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    uf_d    = uf_q;
    if (flush) begin
      bits_d  = '0;
      nb_d    = '0;
      valid_d = 1'b0;
    end else if (!halt) begin
      bits_d  = kept | (word_read ? w_ext << rem : '0);
      nb_d    = rem + (word_read ? NB_W'(WORD_W) : '0);
      valid_d = take;
      if (take) begin
        data_d = bits_q[SAMPLE_W-1:0];
        cnt_d  = cnt_q + CNT_W'(1);
      end else if (sample_en && (uf_q != '1)) begin
        uf_d = uf_q + UF_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bits_q  <= '0;
      nb_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      uf_q    <= '0;
    end else begin
      bits_q  <= bits_d;
      nb_q    <= nb_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      uf_q    <= uf_d;
    end
  end

  assign sample_valid    = valid_q;
  assign sample_data     = data_q;
  assign bits_available  = nb_q;
  assign sample_count    = cnt_q;
  assign underflow_count = uf_q;

endmodule

// File: tb/tb_rtdf_sample_unpacker.sv
// Bench for rtdf_sample_unpacker: two instances (16/3 LSB-first and 16/5
// MSB-first with a 2-bit underflow counter) checked against a bit-queue model.
module tb_rtdf_sample_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, sample_en, flush, halt;
  logic        word_empty [2];
  logic [15:0] word_data  [2];

  wire        rd0, rd1, sv0, sv1;
  wire [2:0]  sd0;
  wire [4:0]  sd1, ba0, ba1;
  wire [31:0] sc0, sc1;
  wire [15:0] uf0;
  wire [1:0]  uf1;

  rtdf_sample_unpacker #(.WORD_W(16), .SAMPLE_W(3), .LSB_FIRST(1),
                         .CNT_W(32), .UF_W(16)) u0 (
    .clk(clk), .reset(reset), .word_empty(word_empty[0]),
    .word_data(word_data[0]), .word_read(rd0), .sample_en(sample_en),
    .flush(flush), .halt(halt), .sample_valid(sv0), .sample_data(sd0),
    .bits_available(ba0), .sample_count(sc0), .underflow_count(uf0));

  rtdf_sample_unpacker #(.WORD_W(16), .SAMPLE_W(5), .LSB_FIRST(0),
                         .CNT_W(32), .UF_W(2)) u1 (
    .clk(clk), .reset(reset), .word_empty(word_empty[1]),
    .word_data(word_data[1]), .word_read(rd1), .sample_en(sample_en),
    .flush(flush), .halt(halt), .sample_valid(sv1), .sample_data(sd1),
    .bits_available(ba1), .sample_count(sc1), .underflow_count(uf1));

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string nm, input int i,
                       input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %0d, expected %0d at %0t",
               nm, i, got, exp, $time);
    end
  endtask

  function automatic int sw(input int i);
    return (i == 0) ? 3 : 5;
  endfunction

  function automatic int ufmax(input int i);
    return (i == 0) ? 65535 : 3;
  endfunction

  // Model: buffered bits as a queue, head = next bit to emit
  bit          mq [2][$];
  logic [15:0] fifo [2][$];
  bit          m_valid [2];
  int unsigned m_data [2];
  int unsigned m_cnt [2];
  int unsigned m_uf [2];
  bit          m_init = 1'b0;

  function automatic bit exp_rd(input int i);
    int n;
    n = mq[i].size();
    if (sample_en && n >= sw(i)) n -= sw(i);
    return !reset && !flush && !halt && !word_empty[i] && (n < sw(i));
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit rd, tk;
      int unsigned d;
      logic [15:0] w;
      rd = exp_rd(i);
      if (reset) begin
        mq[i].delete();
        m_valid[i] = 1'b0;
        m_data[i] = 0;
        m_cnt[i] = 0;
        m_uf[i] = 0;
        m_init = 1'b1;
      end else if (flush) begin
        mq[i].delete();
        m_valid[i] = 1'b0;
      end else if (!halt) begin
        tk = sample_en && (mq[i].size() >= sw(i));
        if (tk) begin
          d = 0;
          for (int b = 0; b < sw(i); b++)
            if (mq[i].pop_front()) d |= (1 << b);
          m_data[i] = d;
          m_cnt[i]++;
        end else if (sample_en && m_uf[i] < ufmax(i)) begin
          m_uf[i]++;
        end
        m_valid[i] = tk;
        if (rd) begin
          w = fifo[i].pop_front();
          for (int b = 0; b < 16; b++)
            mq[i].push_back((i == 0) ? w[b] : w[15-b]);
        end
      end
    end
  end

  longint g_rd [2], g_sv [2], g_sd [2], g_ba [2], g_sc [2], g_uf [2];
  always_comb begin
    g_rd[0] = longint'(rd0); g_rd[1] = longint'(rd1);
    g_sv[0] = longint'(sv0); g_sv[1] = longint'(sv1);
    g_sd[0] = longint'(sd0); g_sd[1] = longint'(sd1);
    g_ba[0] = longint'(ba0); g_ba[1] = longint'(ba1);
    g_sc[0] = longint'(sc0); g_sc[1] = longint'(sc1);
    g_uf[0] = longint'(uf0); g_uf[1] = longint'(uf1);
  end

  always @(negedge clk) begin
    if (m_init) begin
      for (int i = 0; i < 2; i++) begin
        check("word_read", i, g_rd[i], longint'(exp_rd(i)));
        check("sample_valid", i, g_sv[i], longint'(m_valid[i]));
        check("sample_data", i, g_sd[i], longint'(m_data[i]));
        check("bits_available", i, g_ba[i], longint'(mq[i].size()));
        check("sample_count", i, g_sc[i], longint'(m_cnt[i]));
        check("underflow_count", i, g_uf[i], longint'(m_uf[i]));
      end
    end
  end

  task automatic refresh();
    for (int i = 0; i < 2; i++) begin
      word_empty[i] = (fifo[i].size() == 0);
      word_data[i]  = (fifo[i].size() != 0) ? fifo[i][0] : 16'h0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    refresh();
  endtask

  task automatic push(input logic [15:0] w);
    fifo[0].push_back(w);
    fifo[1].push_back(w);
    refresh();
  endtask

  task automatic push_pattern();
    logic [47:0] p;
    for (int i = 0; i < 16; i++) p[3*i +: 3] = 3'(i);
    push(p[15:0]);
    push(p[31:16]);
    push(p[47:32]);
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; flush = 1'b0; halt = 1'b0;
    refresh();
    tick();
    tick();
    reset = 1'b0;
    check("reset_valid", 0, longint'(sv0), 0);
    check("reset_count", 0, longint'(sc0), 0);
    check("reset_nb", 1, longint'(ba1), 0);

    for (int k = 0; k < 5; k++) begin
      sample_en = 1'b1; tick();
      sample_en = 1'b0; tick();
      check("uf_valid", 0, longint'(sv0), 0);
      if (k == 3) check("uf_after4", 0, longint'(uf0), 4);
    end
    check("uf_after5", 0, longint'(uf0), 5);
    check("uf_saturate", 1, longint'(uf1), 3);

    push_pattern();
    tick();
    sample_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("stream_valid", 0, longint'(sv0), 1);
      check("stream_data", 0, longint'(sd0), k % 8);
    end
    sample_en = 1'b0;
    tick();
    check("stream_count", 0, longint'(sc0), 16);
    check("stream_nb", 0, longint'(ba0), 0);
    check("stream_uf", 0, longint'(uf0), 5);

    push(16'hFFFF);
    tick();
    sample_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("ones_data", 0, longint'(sd0), 7);
    end
    tick();
    check("carry_valid", 0, longint'(sv0), 0);
    check("carry_nb", 0, longint'(ba0), 1);
    check("carry_uf", 0, longint'(uf0), 6);
    sample_en = 1'b0;
    push(16'h0000);
    tick();
    sample_en = 1'b1;
    tick();
    check("carry_sample", 0, longint'(sd0), 1);
    check("carry_sval", 0, longint'(sv0), 1);
    sample_en = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush14_nb", 0, longint'(ba0), 0);

    push_pattern();
    tick();
    sample_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("halt_pre", 0, longint'(sd0), k);
    end
    halt = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("halt_rd", 0, longint'(rd0), 0);
      check("halt_sv", 0, longint'(sv0), 1);
      check("halt_sd", 0, longint'(sd0), 7);
      check("halt_nb", 0, longint'(ba0), 8);
    end
    halt = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("halt_post", 0, longint'(sd0), k);
      check("halt_post_v", 0, longint'(sv0), 1);
    end
    sample_en = 1'b0;
    tick();
    check("halt_count", 0, longint'(sc0), 38);
    check("halt_nb_end", 0, longint'(ba0), 0);

    push(16'hFFFF);
    tick();
    sample_en = 1'b1;
    tick(); tick(); tick();
    sample_en = 1'b0;
    check("pre_flush_nb", 0, longint'(ba0), 7);
    flush = 1'b1; sample_en = 1'b1;
    tick();
    flush = 1'b0; sample_en = 1'b0;
    check("flush_nb", 0, longint'(ba0), 0);
    check("flush_sv", 0, longint'(sv0), 0);
    check("flush_cnt", 0, longint'(sc0), 41);
    check("flush_uf", 0, longint'(uf0), 6);
    push(16'h0005);
    tick();
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    check("post_flush_sd", 0, longint'(sd0), 5);
    check("post_flush_sv", 0, longint'(sv0), 1);

    for (int k = 0; k < 4000; k++) begin
      sample_en = 1'($urandom_range(0, 1));
      halt      = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 2; i++)
        if (fifo[i].size() < 3 && $urandom_range(0, 2) != 0)
          fifo[i].push_back(16'($urandom));
      refresh();
      tick();
    end
    sample_en = 1'b0; halt = 1'b0; flush = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
